// File: rtl/controlador_aritmetico_serie_pkg.sv
// ctrl_aritmetico_pkg: opcodes and FSM state encoding shared by the serial arithmetic controller and its 1-bit cell
package ctrl_aritmetico_pkg;
  localparam logic [1:0] OP_SUMA  = 2'b00;
  localparam logic [1:0] OP_RESTA = 2'b01;
  localparam logic [1:0] OP_Y     = 2'b10;
  localparam logic [1:0] OP_OX    = 2'b11;
  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;
endpackage

// File: rtl/controlador_aritmetico_serie_if.sv
// controlador_aritmetico_serie_if: request/result bundle of the serial controller
// master drives Inicio/OperandoA/OperandoB/Operacion and reads Ocupado/Listo/Resultado/Acarreo (+Desborde with CTRL_DESBORDE_EN)
interface controlador_aritmetico_serie_if #(parameter int ANCHO = 8);
  logic             Inicio;
  logic [ANCHO-1:0] OperandoA;
  logic [ANCHO-1:0] OperandoB;
  logic [1:0]       Operacion;
  logic             Ocupado;
  logic             Listo;
  logic [ANCHO-1:0] Resultado;
  logic             Acarreo;
`ifdef CTRL_DESBORDE_EN
  logic             Desborde;
  modport master (output Inicio, OperandoA, OperandoB, Operacion, input Ocupado, Listo, Resultado, Acarreo, Desborde);
  modport slave  (input Inicio, OperandoA, OperandoB, Operacion, output Ocupado, Listo, Resultado, Acarreo, Desborde);
`else
  modport master (output Inicio, OperandoA, OperandoB, Operacion, input Ocupado, Listo, Resultado, Acarreo);
  modport slave  (input Inicio, OperandoA, OperandoB, Operacion, output Ocupado, Listo, Resultado, Acarreo);
`endif
endinterface

// File: rtl/controlador_aritmetico_serie_celda.sv
// celda_aritmetica_1b: combinational 1-bit cell; inputs a, b, cin, op; outputs s, cout (cout is 0 for logic ops)
module celda_aritmetica_1b
  import ctrl_aritmetico_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);
  always_comb begin
    s    = op == OP_Y ? a & b : op == OP_OX ? a ^ b : a ^ b ^ cin;
    cout = op[1] ? 1'b0 : (a & b) | (cin & (a ^ b));
  end
endmodule

// File: rtl/controlador_aritmetico_serie.sv
// controlador_aritmetico_serie: bit-serial sequencer streaming two ANCHO-bit operands LSB-first through one 1-bit cell
// Ports: Reloj, Reinicio (async, active-high), bus (slave side of controlador_aritmetico_serie_if).
// Macro CTRL_DESBORDE_EN adds the signed-overflow output Desborde.
module controlador_aritmetico_serie
  import ctrl_aritmetico_pkg::*;
#(
  parameter int ANCHO = 8
) (
  input logic                              Reloj,
  input logic                              Reinicio,
  controlador_aritmetico_serie_if.slave    bus
);
  localparam int ANCHO_CNT = $clog2(ANCHO) + 1;
  estado_t              estado;
  logic [ANCHO-1:0]     a_r, b_r, res;
  logic [1:0]           op_r;
  logic [ANCHO_CNT-1:0] cnt;
  logic                 carry, s, cout, listo, ocupado, acarreo;
  celda_aritmetica_1b u_celda (
    .a    (a_r[0]),
    .b    (op_r == OP_RESTA ? ~b_r[0] : b_r[0]),
    .cin  (carry),
    .op   (op_r),
    .s    (s),
    .cout (cout)
  );
`ifdef CTRL_DESBORDE_EN
  logic desborde;
  assign bus.Desborde = desborde;
`endif
  // FIN also accepts Inicio so back-to-back ops run every ANCHO+1 cycles.
  always_ff @(posedge Reloj or posedge Reinicio) begin
    if (Reinicio) begin
      estado  <= REPOSO;
      a_r     <= '0;
      b_r     <= '0;
      res     <= '0;
      op_r    <= OP_SUMA;
      cnt     <= '0;
      carry   <= 1'b0;
      listo   <= 1'b0;
      ocupado <= 1'b0;
      acarreo <= 1'b0;
`ifdef CTRL_DESBORDE_EN
      desborde <= 1'b0;
`endif
    end else begin
      listo <= 1'b0;
      case (estado)
        CALCULO: begin
          res   <= {s, res[ANCHO-1:1]};
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == ANCHO_CNT'(ANCHO - 1)) begin
            estado  <= FIN;
            listo   <= 1'b1;
            acarreo <= cout;
`ifdef CTRL_DESBORDE_EN
            desborde <= carry ^ cout;
`endif
          end
        end
        default: begin
          if (bus.Inicio) begin
            estado  <= CALCULO;
            ocupado <= 1'b1;
            a_r     <= bus.OperandoA;
            b_r     <= bus.OperandoB;
            op_r    <= bus.Operacion;
            cnt     <= '0;
            carry   <= bus.Operacion == OP_RESTA;
          end else begin
            estado  <= REPOSO;
            ocupado <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bus.Ocupado   = ocupado;
  assign bus.Listo     = listo;
  assign bus.Resultado = res;
  assign bus.Acarreo   = acarreo;
endmodule
